// File: rtl/demux_array.sv
// Output-side scatter stage: gathers Pout-lane beats group by group into an
// Nout-channel vector and presents it on a registered valid/ready output.
module demux_array #(
    parameter int unsigned Nout      = 3,
    parameter int unsigned Pout      = 2,
    parameter int unsigned BIT_WIDTH = 8,
    localparam int unsigned NUM_GROUP = (Nout + Pout - 1) / Pout,
    localparam int unsigned GW        = (NUM_GROUP > 1) ? $clog2(NUM_GROUP) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [Pout*BIT_WIDTH-1:0] in_data,
    output logic [GW-1:0]             group_idx,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [Nout*BIT_WIDTH-1:0] out_data
);

    // Channels owned by groups 0..NUM_GROUP-2; the last group goes straight to out_data.
    localparam int unsigned LAST_BASE = (NUM_GROUP - 1) * Pout;
    localparam int unsigned BUF_CH    = (LAST_BASE > 0) ? LAST_BASE : 1;
    localparam int unsigned BW        = BIT_WIDTH;

    logic [GW-1:0]        group_q, group_d;
    logic [BUF_CH*BW-1:0] buf_q, buf_d;
    logic                 out_valid_q, out_valid_d;
    logic [Nout*BW-1:0]   out_data_q, out_data_d;

    logic is_last;
    logic accept;

    assign is_last   = (group_q == GW'(NUM_GROUP - 1));
    assign in_ready  = !clear && !(is_last && out_valid_q && !out_ready);
    assign accept    = in_valid && in_ready;

    assign group_idx = group_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        group_d     = group_q;
        buf_d       = buf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clear) begin
            group_d = '0;
        end else if (accept) begin
            if (!is_last) begin
                for (int unsigned g = 0; g < NUM_GROUP - 1; g++) begin
                    for (int unsigned i = 0; i < Pout; i++) begin
                        if (group_q == GW'(g)) begin
                            buf_d[(g*Pout + i)*BW +: BW] = in_data[i*BW +: BW];
                        end
                    end
                end
                group_d = group_q + GW'(1);
            end else begin
                // Merge stored groups with the live last beat; lanes past Nout fall off.
                for (int unsigned c = 0; c < Nout; c++) begin
                    if (c < LAST_BASE) begin
                        out_data_d[c*BW +: BW] = buf_q[c*BW +: BW];
                    end else begin
                        out_data_d[c*BW +: BW] = in_data[(c - LAST_BASE)*BW +: BW];
                    end
                end
                out_valid_d = 1'b1;
                group_d     = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            group_q     <= '0;
            buf_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            group_q     <= group_d;
            buf_q       <= buf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_demux_array.sv
// Directed bench for demux_array: default 3/2/8 instance with a scoreboard on
// the output handshake, plus a 4/4/8 instance for the single-group corner.
module tb_demux_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clear, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data;
    logic [0:0]  group_idx;
    logic [23:0] out_data;

    logic        c_clear, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [31:0] c_in_data, c_out_data;
    logic [0:0]  c_group_idx;

    demux_array #(.Nout(3), .Pout(2), .BIT_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .group_idx(group_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    demux_array #(.Nout(4), .Pout(4), .BIT_WIDTH(8)) u_corner (
        .clk(clk), .rst(rst), .clear(c_clear),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .group_idx(c_group_idx),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_stall = 0;
    int          n_hs    = 0;
    logic [23:0] sb_q[$];
    logic        mdl_g;
    logic [23:0] mdl_vec;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: group 0 fills channels 0,1; group 1 lane 0 fills channel 2, lane 1 dropped.
    task automatic model_accept(input logic [15:0] beat);
        if (mdl_g == 1'b0) begin
            mdl_vec[15:0] = beat;
            mdl_g = 1'b1;
        end else begin
            mdl_vec[23:16] = beat[7:0];
            sb_q.push_back(mdl_vec);
            mdl_g = 1'b0;
        end
    endtask

    task automatic send(input logic [15:0] beat);
        int waited = 0;
        bit done   = 1'b0;
        in_valid = 1'b1;
        in_data  = beat;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                check("group_idx", 32'(group_idx), 32'(mdl_g));
                model_accept(beat);
                done = 1'b1;
            end else begin
                waited++;
                n_stall++;
                if (waited > 20) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL send_timeout: observed %0d stalled cycles expected at most 20", waited);
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_hs++;
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL sb_empty: observed %0h expected no output", out_data);
            end else begin
                check("sb_vector", 32'(out_data), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] b0, b1;
        int stall0, hs0;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        c_clear = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
        mdl_g = 1'b0; mdl_vec = '0;

        #12;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_group_idx", 32'(group_idx), 32'(0));
        check("rst_c_out_valid", 32'(c_out_valid), 32'(0));
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Basic assembly
        out_ready = 1'b1;
        send(16'h2211);
        send(16'h4433);
        @(negedge clk);
        check("basic_valid", 32'(out_valid), 32'(1));
        check("basic_data", 32'(out_data), 32'h332211);
        check("basic_group_wrap", 32'(group_idx), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("valid_drop", 32'(out_valid), 32'(0));
        @(posedge clk); #1;

        // Backpressure on the last group only
        out_ready = 1'b0;
        send(16'h2211);
        send(16'h4433);
        send(16'h6655);
        in_valid = 1'b1;
        in_data  = 16'h8877;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'(0));
            check("bp_hold_data", 32'(out_data), 32'h332211);
            check("bp_hold_valid", 32'(out_valid), 32'(1));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'(1));
        model_accept(16'h8877);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_valid", 32'(out_valid), 32'(1));
        check("bp_next_data", 32'(out_data), 32'h776655);
        @(posedge clk); #1;

        // Back-to-back full rate
        stall0 = n_stall;
        hs0    = n_hs;
        for (int v = 0; v < 4; v++) begin
            b0 = 16'($urandom);
            b1 = 16'($urandom);
            send(b0);
            send(b1);
        end
        repeat (3) begin @(posedge clk); #1; end
        check("b2b_stalls", 32'(n_stall - stall0), 32'(0));
        check("b2b_vectors", 32'(n_hs - hs0), 32'(4));

        // Clear mid-vector
        send(16'h2211);
        clear = 1'b1; in_valid = 1'b1; in_data = 16'hAAAA;
        @(negedge clk);
        check("clear_in_ready", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        mdl_g = 1'b0;
        @(negedge clk);
        check("clear_group_idx", 32'(group_idx), 32'(0));
        @(posedge clk); #1;
        send(16'hBBCC);
        send(16'hDDEE);
        @(negedge clk);
        check("clear_data", 32'(out_data), 32'hEEBBCC);
        @(posedge clk); #1;

        // Async reset with a held vector and a partial one
        out_ready = 1'b0;
        send(16'h2211);
        send(16'h4433);
        send(16'h6655);
        @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), 32'(1));
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'(0));
        check("arst_data", 32'(out_data), 32'(0));
        check("arst_group_idx", 32'(group_idx), 32'(0));
        sb_q.delete();
        mdl_g = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'h0102);
        send(16'h0304);
        @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 32'(1));
        check("post_rst_data", 32'(out_data), 32'h040102);
        @(posedge clk); #1;

        // Single-group corner: Nout = Pout = 4
        c_out_ready = 1'b0;
        c_in_valid  = 1'b1;
        c_in_data   = 32'hDEADBEEF;
        @(negedge clk);
        check("c_in_ready", 32'(c_in_ready), 32'(1));
        check("c_group_idx", 32'(c_group_idx), 32'(0));
        @(posedge clk); #1;
        c_in_data = 32'h12345678;
        repeat (2) begin
            @(negedge clk);
            check("c_valid", 32'(c_out_valid), 32'(1));
            check("c_data", c_out_data, 32'hDEADBEEF);
            check("c_stall", 32'(c_in_ready), 32'(0));
            @(posedge clk); #1;
        end
        c_out_ready = 1'b1;
        @(negedge clk);
        check("c_release_ready", 32'(c_in_ready), 32'(1));
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        @(negedge clk);
        check("c_next_valid", 32'(c_out_valid), 32'(1));
        check("c_next_data", c_out_data, 32'h12345678);
        @(posedge clk); #1;
        @(negedge clk);
        check("c_drain_valid", 32'(c_out_valid), 32'(0));

        check("sb_leftover", 32'(sb_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_array.md
Name: demux_array

Overview:
- Output-side counterpart of the line-buffer input mux stage: collects Pout computed results per cycle and scatters them, group by group, into an Nout-channel output vector.
- Group g, lane i writes output channel i+g*Pout. After NUM_GROUP accepted groups, the full vector is presented on a registered valid/ready output.
- Sits between the Pout-wide PE/accumulator array and the Nout-wide output feature-map writer.

Parameters:
- Nout, 3, output feature map number (channels in the assembled vector).
- Pout, 2, output feature map parallelism (lanes per input beat).
- BIT_WIDTH, 8, bit width per channel.
- NUM_GROUP, ceil_div(Nout, Pout), derived; beats per vector; not to be overridden.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- clear  input  1  synchronous abort of the partially assembled vector.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid&&in_ready.
- in_data  input  Pout*BIT_WIDTH  lane i at bits [i*BIT_WIDTH +: BIT_WIDTH].
- group_idx  output  clog2(NUM_GROUP) (min 1)  index of the group the next accepted beat fills.
- out_valid  output  1  assembled vector valid.
- out_ready  input  1  downstream accepts when out_valid&&out_ready.
- out_data  output  Nout*BIT_WIDTH  channel c at bits [c*BIT_WIDTH +: BIT_WIDTH].

Behaviour:
- Reset (async, rst=1): group_idx=0, assembly buffer=0, out_valid=0, out_data=0. Any partial vector is discarded. Operation resumes at group 0 on the first edge after deassertion.
- Accept: beat = in_valid && in_ready.
  - Non-last group (group_idx<NUM_GROUP-1): write lanes into the assembly buffer at channels i+group_idx*Pout, then group_idx++.
  - Last group: out_data <= assembly buffer merged with this beat's lanes; out_valid <= 1; group_idx <= 0.
- Tail lanes: lanes where i+g*Pout >= Nout are dropped (no storage, no effect).
- Latency: out_valid rises the cycle after the last-group beat is accepted.
- in_ready = !clear && !(group_idx==NUM_GROUP-1 && out_valid && !out_ready).
  - Non-last groups are never backpressured.
  - The last group stalls only while a previous vector is held.
  - A last-group beat coinciding with an output handshake is accepted: zero-bubble streaming.
- Output hold: while out_valid && !out_ready, out_data and out_valid stay stable.
  - Handshake with no new last beat: out_valid <= 0. out_data holds its last value (don't-care).
- clear=1: group_idx <= 0; in_ready is forced 0, so no beat is accepted in that cycle. The assembly buffer contents are irrelevant, since every channel is overwritten before the next output. out_valid/out_data are unaffected; a held vector still drains normally.
- Corner Nout==Pout (NUM_GROUP=1): group_idx is constantly 0. Every accepted beat loads out_data directly; same handshake rules.
- The assembly buffer needs only channels belonging to groups 0..NUM_GROUP-2. The last group's channels are written straight into out_data.

Test Plan:
- Basic assembly (Nout=3,Pout=2,BW=8): beat0 in_data=16'h2211, beat1=16'h4433 on consecutive cycles, out_ready=1 -> cycle after beat1: out_valid=1, out_data=24'h332211 (0x44 dropped); group_idx sequence 0,1,0.
- Backpressure: out_ready=0, stream vectors {0x2211,0x4433} then {0x6655,0x8877} -> second vector's beat0 accepted, beat1 sees in_ready=0; out_data stays 24'h332211. Raise out_ready -> next cycle out_data=24'h776655, out_valid=1.
- Back-to-back full rate, out_ready=1, 4 vectors -> in_ready constantly 1, one out_valid pulse every 2 cycles, all data correct.
- Clear mid-vector: accept beat0=0x2211, assert clear with in_valid=1 beat=0xAAAA -> not accepted, group_idx=0. Then beats 0xBBCC,0xDDEE -> out_data=24'hEEBBCC.
- Async reset mid-vector with out_valid=1 held -> same cycle out_valid=0, out_data=0, group_idx=0. Next vector assembles correctly.
- Corner Nout=Pout=4: beat 32'hDEADBEEF -> next cycle out_data=32'hDEADBEEF, out_valid=1. With out_ready=0, in_ready=0 until drain.
